// File: rtl/ysyx_22050039_gpr_bank.sv
// General-purpose register bank for the ysyx_22050039 RV64 core.
// Built from a key-lookup mux and a resettable write-enabled register.
// Register 0 is hardwired to zero; both read ports are combinational.

// Key-lookup mux: pair 0 sits in the most significant position of lut.
// The lowest-indexed matching pair wins; no match yields all zeros.
module ysyx_22050039_mux_key #(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1
) (
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                  out
);

  localparam int unsigned PairLen = KEY_LEN + DATA_LEN;

  // Scan pairs in index order and keep the first hit.
  always_comb begin
    logic hit;
    hit = 1'b0;
    out = '0;
    for (int i = 0; i < int'(NR_KEY); i++) begin
      if (!hit && (lut[(int'(NR_KEY) - 1 - i) * int'(PairLen) + int'(DATA_LEN) +: KEY_LEN] == key))
      begin
        out = lut[(int'(NR_KEY) - 1 - i) * int'(PairLen) +: DATA_LEN];
        hit = 1'b1;
      end
    end
  end

endmodule

// Resettable register with write enable.
module ysyx_22050039_reg #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  // Asynchronous reset dominates; otherwise load on enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// Register bank top. NR_REG must equal 2**REG_SEL.
module ysyx_22050039_gpr_bank #(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     NR_REG    = 32,
  parameter int unsigned     REG_SEL   = 5,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [REG_SEL-1:0]       waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [REG_SEL-1:0]       raddr1,
  input  logic [REG_SEL-1:0]       raddr2,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2,
  output logic [NR_REG*XLEN-1:0]   regs_flat
);

  localparam int unsigned       WdecPair = REG_SEL + NR_REG;
  localparam int unsigned       RdPair   = REG_SEL + XLEN;
  localparam logic [NR_REG-1:0] OneHot0  = NR_REG'(1);
  localparam logic [XLEN-1:0]   Zero     = '0;

  logic [NR_REG*WdecPair-1:0] wdec_lut;
  logic [NR_REG*RdPair-1:0]   rd_lut;
  logic [NR_REG-1:0]          each_wen;
  logic [NR_REG-1:0]          reg_wen;
  logic [XLEN-1:0]            regs [NR_REG];

  for (genvar k = 0; k < NR_REG; k++) begin : gen_lut
    assign wdec_lut[(NR_REG-1-k)*WdecPair +: WdecPair] = {REG_SEL'(k), OneHot0 << k};
    assign rd_lut[(NR_REG-1-k)*RdPair +: RdPair]       = {REG_SEL'(k), regs[k]};
    assign regs_flat[k*XLEN +: XLEN]                   = regs[k];
  end

  ysyx_22050039_mux_key #(
    .NR_KEY  (NR_REG),
    .KEY_LEN (REG_SEL),
    .DATA_LEN(NR_REG)
  ) u_wdec (
    .key(waddr),
    .lut(wdec_lut),
    .out(each_wen)
  );

  for (genvar k = 0; k < NR_REG; k++) begin : gen_reg
    // Register 0 never loads and resets to zero, so it always reads zero.
    assign reg_wen[k] = (k == 0) ? 1'b0 : (wen & each_wen[k]);

    ysyx_22050039_reg #(
      .WIDTH    (XLEN),
      .RESET_VAL((k == 0) ? Zero : RESET_VAL)
    ) u_reg (
      .clk (clk),
      .rst (rst),
      .din (wdata),
      .dout(regs[k]),
      .wen (reg_wen[k])
    );
  end

  ysyx_22050039_mux_key #(
    .NR_KEY  (NR_REG),
    .KEY_LEN (REG_SEL),
    .DATA_LEN(XLEN)
  ) u_rd1 (
    .key(raddr1),
    .lut(rd_lut),
    .out(rdata1)
  );

  ysyx_22050039_mux_key #(
    .NR_KEY  (NR_REG),
    .KEY_LEN (REG_SEL),
    .DATA_LEN(XLEN)
  ) u_rd2 (
    .key(raddr2),
    .lut(rd_lut),
    .out(rdata2)
  );

endmodule

// File: tb/tb_ysyx_22050039_gpr_bank.sv
// Directed testbench for the register bank with hand-computed expectations.
module tb_ysyx_22050039_gpr_bank;

  logic          clk = 1'b0;
  logic          rst;
  logic          wen;
  logic [4:0]    waddr;
  logic [63:0]   wdata;
  logic [4:0]    raddr1;
  logic [4:0]    raddr2;
  logic [63:0]   rdata1;
  logic [63:0]   rdata2;
  logic [2047:0] regs_flat;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [63:0] exp_regs [32];

  always #5 clk = ~clk;

  ysyx_22050039_gpr_bank dut (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .regs_flat(regs_flat)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%016h, want 0x%016h", tag, got, want);
    end
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [63:0] d);
    wen   = 1'b1;
    waddr = a;
    wdata = d;
    step();
    wen   = 1'b0;
    if (a != 5'd0) exp_regs[a] = d;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      check_eq($sformatf("%s_r%0d", tag, i), regs_flat[i*64 +: 64], exp_regs[i]);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) exp_regs[i] = 64'd0;
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    clear_model();
    step();
    step();
    raddr1 = 5'd3; raddr2 = 5'd31; #1;
    check_eq("rst_rdata1", rdata1, 64'd0);
    check_eq("rst_rdata2", rdata2, 64'd0);
    check_all("rst");
    rst = 1'b0;

    // Basic write visible after one edge.
    raddr1 = 5'd1;
    write(5'd1, 64'h8000_0000_0000_0004);
    check_eq("w1_rdata1", rdata1, 64'h8000_0000_0000_0004);
    check_all("w1");

    // Writes to register 0 are dropped.
    raddr2 = 5'd0;
    write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("w0_rdata2", rdata2, 64'd0);
    check_eq("w0_flat", regs_flat[63:0], 64'd0);

    // Disabled write then enabled write.
    wen = 1'b0; waddr = 5'd5; wdata = 64'h1234; raddr1 = 5'd5;
    step();
    check_eq("wen0_r5", rdata1, 64'd0);
    write(5'd5, 64'h1234);
    check_eq("wen1_r5", rdata1, 64'h1234);

    // Same-cycle read/write on index 31, neighbour 30 untouched.
    write(5'd31, 64'h55);
    write(5'd30, 64'h77);
    raddr1 = 5'd31; raddr2 = 5'd30;
    wen = 1'b1; waddr = 5'd31; wdata = 64'hDEAD_BEEF; #1;
    check_eq("r31_before", rdata1, 64'h55);
    step();
    wen = 1'b0;
    exp_regs[31] = 64'hDEAD_BEEF;
    check_eq("r31_after", rdata1, 64'hDEAD_BEEF);
    check_eq("r30_keep", rdata2, 64'h77);

    // Back-to-back writes.
    write(5'd2, 64'hA);
    write(5'd3, 64'hB);
    write(5'd2, 64'hC);
    raddr1 = 5'd2; raddr2 = 5'd3; #1;
    check_eq("b2b_r2", rdata1, 64'hC);
    check_eq("b2b_r3", rdata2, 64'hB);
    check_all("b2b");

    // Asynchronous reset mid-cycle during an active write.
    raddr1 = 5'd31; raddr2 = 5'd2;
    wen = 1'b1; waddr = 5'd7; wdata = 64'h7777; #2;
    rst = 1'b1; #1;
    clear_model();
    check_eq("arst_rdata1", rdata1, 64'd0);
    check_eq("arst_rdata2", rdata2, 64'd0);
    check_all("arst");
    step();
    check_eq("arst_r7_lost", regs_flat[7*64 +: 64], 64'd0);

    // First edge after reset release accepts a write.
    rst = 1'b0;
    raddr1 = 5'd9;
    write(5'd9, 64'h99);
    check_eq("post_rst_r9", rdata1, 64'h99);
    check_all("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
